sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in / parallel-out frame assembler with a ready/valid handoff.
// Bits arrive one per valid beat and are collected into a WIDTH-bit word.
// A completed word is held until the consumer takes it. A frame start that
// arrives while a word is still waiting is dropped and flagged as an overrun.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    // Counter value held just before the final bit of a frame is accepted
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic [7:0]       frame_cnt_reg;
    logic             overrun_reg;

    // Control strobes produced by the next-state logic
    logic shift_en;   // accept din into the shift register this cycle
    logic restart;    // the accepted bit is bit 0 of a new frame
    logic handshake;  // held word is taken by the consumer
    logic ovr_set;    // frame start dropped while holding a word

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        restart    = 1'b0;
        handshake  = 1'b0;
        ovr_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && din_valid) begin
                    shift_en   = 1'b1;
                    restart    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Without din_valid the frame simply stalls
                if (din_valid) begin
                    shift_en = 1'b1;
                    if (start) begin
                        // Abort and begin again with this bit as bit 0
                        restart = 1'b1;
                    end else if (cnt_reg == LAST_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    if (start && din_valid) begin
                        // Back-to-back: next frame starts in the handoff cycle
                        shift_en   = 1'b1;
                        restart    = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (start && din_valid) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded directly from the state register (no extra lag)
    always_comb begin
        out_valid = (state_reg == HOLD);
        busy      = (state_reg != IDLE);
    end

    // Shift register, bit counter, delivered-frame counter and overrun flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg      <= '0;
            cnt_reg       <= '0;
            frame_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            // New bits enter at the MSB so the first bit ends in bit 0
            if (shift_en) begin
                data_reg <= {din, data_reg[WIDTH-1:1]};
            end
            if (restart) begin
                cnt_reg <= CW'(1);
            end else if (shift_en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (handshake) begin
                cnt_reg <= '0;
            end
            if (handshake) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            // A set in the same cycle as a clear takes priority
            if (ovr_set) begin
                overrun_reg <= 1'b1;
            end else if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign out_data  = data_reg;
    assign overrun   = overrun_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl (WIDTH=4): a table of directed
// vectors, hand-written multi-cycle sequences, then random stimulus checked
// against a queue-based behavioural model.
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         din;
    logic         din_valid;
    logic         out_ready;
    logic         clr_ovr;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic [7:0]   frame_cnt;

    int errors = 0;
    int checks = 0;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model: every accepted bit since reset is kept in m_hist;
    // the parallel word is simply the last W accepted bits, newest at MSB.
    // ------------------------------------------------------------------
    bit m_hist[$];
    bit m_frame[$];
    bit m_collect = 1'b0;
    bit m_hold    = 1'b0;
    bit m_ovr     = 1'b0;
    int m_fcnt    = 0;

    task automatic m_accept(input bit d);
        m_hist.push_back(d);
        if (m_hist.size() > W) void'(m_hist.pop_front());
    endtask

    task automatic m_new_frame(input bit d);
        m_accept(d);
        m_frame.delete();
        m_frame.push_back(d);
        m_collect = 1'b1;
    endtask

    task automatic model_step(input bit r, input bit s, input bit d,
                              input bit v, input bit o, input bit c);
        bit sv;
        bit set_ovr;
        sv      = s && v;
        set_ovr = 1'b0;
        if (!r) begin
            m_hist.delete();
            m_frame.delete();
            m_collect = 1'b0;
            m_hold    = 1'b0;
            m_ovr     = 1'b0;
            m_fcnt    = 0;
        end else begin
            if (m_hold) begin
                if (o) begin
                    m_fcnt    = (m_fcnt + 1) % 256;
                    m_hold    = 1'b0;
                    m_collect = 1'b0;
                    if (sv) m_new_frame(d);
                end else if (sv) begin
                    set_ovr = 1'b1;
                end
            end else if (m_collect) begin
                if (v) begin
                    if (s) begin
                        m_new_frame(d);
                    end else begin
                        m_accept(d);
                        m_frame.push_back(d);
                    end
                    if (m_frame.size() == W) begin
                        m_hold    = 1'b1;
                        m_collect = 1'b0;
                        m_frame.delete();
                    end
                end
            end else if (sv) begin
                m_new_frame(d);
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (c)  m_ovr = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] model_data();
        logic [W-1:0] e;
        int n;
        e = '0;
        n = m_hist.size();
        for (int k = 0; k < n; k++) e[W-n+k] = m_hist[k];
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_data, input bit e_ov,
                           input bit e_busy, input bit e_ovr, input logic [7:0] e_fcnt);
        chk({tag, ".out_data"},  32'(out_data),  32'(e_data));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".overrun"},   32'(overrun),   32'(e_ovr));
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(e_fcnt));
    endtask

    // One clock cycle: apply inputs, step the model at the edge, settle #1
    task automatic drive(input bit r, input bit s, input bit d,
                         input bit v, input bit o, input bit c);
        rst_n     = r;
        start     = s;
        din       = d;
        din_valid = v;
        out_ready = o;
        clr_ovr   = c;
        if (r && out_valid && o)
            $display("frame handoff: data=%h frame_cnt_before=%0d", out_data, frame_cnt);
        @(posedge clk);
        model_step(r, s, d, v, o, c);
        #1;
    endtask

    task automatic beat(input bit s, input bit d);
        drive(1'b1, s, d, 1'b1, 1'b0, 1'b0);
    endtask

    // Send a frame, bits[0] first, then hand it off; checks the held word
    task automatic send_frame(input logic [W-1:0] bits, input string tag);
        for (int k = 0; k < W; k++) beat(k == 0, bits[k]);
        chk({tag, ".held_data"}, 32'(out_data), 32'(bits));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit           r, s, d, v, o, c;
        logic [W-1:0] e_data;
        bit           e_ov, e_busy, e_ovr;
        logic [7:0]   e_fcnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        rst_n = 1'b0; start = 1'b0; din = 1'b0;
        din_valid = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;

        //         r  s  d  v  o  c   data  ov bsy ovr fcnt
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0, 1'b0,1'b0,1'b0, 8'd0}; // reset, inputs busy
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 4'h0, 1'b0,1'b0,1'b0, 8'd0}; // reset, inputs toggled
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 4'h8, 1'b0,1'b1,1'b0, 8'd0}; // bit0=1
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 4'h4, 1'b0,1'b1,1'b0, 8'd0}; // bit1=0
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 4'hA, 1'b0,1'b1,1'b0, 8'd0}; // bit2=1
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 4'hD, 1'b1,1'b1,1'b0, 8'd0}; // bit3=1 -> HOLD
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 4'hD, 1'b1,1'b1,1'b0, 8'd0}; // din_valid w/o start ignored
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 4'hD, 1'b1,1'b1,1'b1, 8'd0}; // start in HOLD -> overrun
        vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 4'hD, 1'b1,1'b1,1'b1, 8'd0}; // sticky
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 4'hD, 1'b1,1'b1,1'b1, 8'd0}; // set beats clear
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'hD, 1'b1,1'b1,1'b0, 8'd0}; // clear
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 4'hD, 1'b0,1'b0,1'b0, 8'd1}; // handshake
        vecs[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 4'hD, 1'b0,1'b0,1'b0, 8'd1}; // idle: valid w/o start
        vecs[13] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 4'hD, 1'b0,1'b0,1'b0, 8'd1}; // idle: start w/o valid

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].o, vecs[i].c);
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ov,
                    vecs[i].e_busy, vecs[i].e_ovr, vecs[i].e_fcnt);
        end

        // Same frame 1,0,1,1 with two idle beats between bits
        beat(1'b1, 1'b1);
        for (int k = 1; k < W; k++) begin
            for (int g = 0; g < 2; g++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("gap.busy", 32'(busy), 32'd1);
                chk("gap.out_valid", 32'(out_valid), 32'd0);
            end
            beat(1'b0, (k == 2 || k == 3));
        end
        chk("gap.out_valid_end", 32'(out_valid), 32'd1);
        chk("gap.out_data", 32'(out_data), 32'hD);

        // Handshake with a new start (din=0), then 1,1,0: no idle cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b.out_valid", 32'(out_valid), 32'd0);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.frame_cnt", 32'(frame_cnt), 32'd2);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        chk("b2b.out_valid2", 32'(out_valid), 32'd1);
        chk("b2b.out_data", 32'(out_data), 32'h6);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b.frame_cnt3", 32'(frame_cnt), 32'd3);
        chk("b2b.idle", 32'(busy), 32'd0);

        // Deliver frames up to the 8-bit wrap
        for (int f = 0; f < 252; f++) send_frame(W'($urandom), "wrap");
        chk("wrap.frame_cnt255", 32'(frame_cnt), 32'd255);
        send_frame(4'h9, "wrap_last");
        chk("wrap.frame_cnt0", 32'(frame_cnt), 32'd0);

        // Restart after two bits: frame built from new bits 0,1,0,1 only
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        chk("restart.not_yet", 32'(out_valid), 32'd0);
        beat(1'b0, 1'b1);
        chk("restart.out_valid", 32'(out_valid), 32'd1);
        chk("restart.out_data", 32'(out_data), 32'hA);
        chk("restart.overrun", 32'(overrun), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart.frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset after three bits discards the partial frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        // Reset while holding with out_ready high: no handoff counted
        for (int k = 0; k < W; k++) beat(k == 0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        // First edge after reset release accepts a start
        beat(1'b1, 1'b1);
        chk("post_rst.busy", 32'(busy), 32'd1);
        chk("post_rst.out_data", 32'(out_data), 32'h8);

        // Random stimulus against the behavioural model
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(63) != 0), ($urandom_range(3) == 0), 1'($urandom),
                  ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(7) == 0));
            chk_all($sformatf("rand%0d", i), model_data(), m_hold,
                    (m_hold || m_collect), m_ovr, 8'(m_fcnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
